// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   FWD_*      : EX operand source select encodings
//   sb_entry_t : scoreboard entry {valid, regWrite, dest, isLoad}
//   BUBBLE     : empty scoreboard entry (a NOP in that stage)
//   sb_match   : true when an in-flight entry produces the given source register
package pipeline_pkg;

    localparam int SB_REG_W = 5;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;
    localparam logic [1:0] FWD_WBHOLD  = 2'b11;

    typedef struct packed {
        logic                valid;
        logic                regWrite;
        logic [SB_REG_W-1:0] dest;
        logic                isLoad;
    } sb_entry_t;

    localparam sb_entry_t BUBBLE = '0;

    // r0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic sb_match(input sb_entry_t e, input logic [SB_REG_W-1:0] r);
        return e.valid & e.regWrite & (e.dest == r) & (r != '0);
    endfunction

endpackage

// File: rtl/hazard_compare.sv
// One ID source register against the EX/MEM/WB scoreboard entries.
// Ports:
//   i_src, i_uses               : source register number and its use flag
//   i_sbEx, i_sbMem, i_sbWb     : scoreboard entries, youngest first
//   o_hazard                    : this source must stall decode
//   o_fwdSel                    : operand source select for EX
// Macro FORWARDING_EN: defined -> only load-use in EX stalls and o_fwdSel picks
// the youngest producer; undefined -> any producer in flight stalls, o_fwdSel=00.
module hazard_compare
    import pipeline_pkg::*;
(
    input  logic [SB_REG_W-1:0] i_src,
    input  logic                i_uses,
    input  sb_entry_t           i_sbEx,
    input  sb_entry_t           i_sbMem,
    input  sb_entry_t           i_sbWb,
    output logic                o_hazard,
    output logic [1:0]          o_fwdSel
);

    logic w_mEx, w_mMem, w_mWb;

    assign w_mEx  = i_uses & sb_match(i_sbEx,  i_src);
    assign w_mMem = i_uses & sb_match(i_sbMem, i_src);
    assign w_mWb  = i_uses & sb_match(i_sbWb,  i_src);

    // isLoad of the older stages is never needed to decide a hazard.
    logic w_unused;
    assign w_unused = &{1'b0, i_sbEx.isLoad, i_sbMem.isLoad, i_sbWb.isLoad};

`ifdef FORWARDING_EN
    always_comb begin
        o_hazard = w_mEx & i_sbEx.isLoad;   // load data not ready until after MEM
        o_fwdSel = FWD_REGFILE;
        if (w_mEx)       o_fwdSel = FWD_EXMEM;   // youngest producer wins
        else if (w_mMem) o_fwdSel = FWD_MEMWB;
        else if (w_mWb)  o_fwdSel = FWD_WBHOLD;
    end
`else
    always_comb begin
        o_hazard = w_mEx | w_mMem | w_mWb;
        o_fwdSel = FWD_REGFILE;
    end
`endif

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard/flush/forward sequencing around the decode stage of a 5-stage pipeline.
// A 3-entry scoreboard (EX, MEM, WB) follows the destinations of in-flight
// instructions; branches resolve in MEM and flush IF/ID, ID/EX and EX/MEM.
// Ports:
//   clk, reset (sync, active high)
//   idValid, idRs, idRt, idUsesRs, idUsesRt, idDest, idRegWrite, idIsLoad : ID instr
//   branchTaken                       : taken branch in MEM
//   stallFetch, bubbleDecode          : same-cycle stall of PC/IFID, NOP into IDEX
//   flushIfId, flushIdEx, flushExMem  : same-cycle squash on taken branch
//   forwardA, forwardB                : registered EX operand selects
//   stallCount                        : saturating stall-cycle counter
// Macro FORWARDING_EN enables operand forwarding (otherwise selects stay 00).
// REG_ADDR_W must match the scoreboard dest width in pipeline_pkg.
module pipeline_hazard_controller
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W  = SB_REG_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   idValid,
    input  logic [REG_ADDR_W-1:0]  idRs,
    input  logic [REG_ADDR_W-1:0]  idRt,
    input  logic                   idUsesRs,
    input  logic                   idUsesRt,
    input  logic [REG_ADDR_W-1:0]  idDest,
    input  logic                   idRegWrite,
    input  logic                   idIsLoad,
    input  logic                   branchTaken,
    output logic                   stallFetch,
    output logic                   bubbleDecode,
    output logic                   flushIfId,
    output logic                   flushIdEx,
    output logic                   flushExMem,
    output logic [1:0]             forwardA,
    output logic [1:0]             forwardB,
    output logic [STALL_CNT_W-1:0] stallCount
);

    sb_entry_t              r_sbEx, r_sbMem, r_sbWb;
    logic [1:0]             r_fwdA, r_fwdB;
    logic [STALL_CNT_W-1:0] r_stallCnt;

    logic       w_hazRs, w_hazRt, w_stall, w_kill;
    logic [1:0] w_fwdA, w_fwdB;
    sb_entry_t  w_idEntry;

    hazard_compare u_cmpRs (
        .i_src   (idRs),
        .i_uses  (idUsesRs),
        .i_sbEx  (r_sbEx),
        .i_sbMem (r_sbMem),
        .i_sbWb  (r_sbWb),
        .o_hazard(w_hazRs),
        .o_fwdSel(w_fwdA)
    );

    hazard_compare u_cmpRt (
        .i_src   (idRt),
        .i_uses  (idUsesRt),
        .i_sbEx  (r_sbEx),
        .i_sbMem (r_sbMem),
        .i_sbWb  (r_sbWb),
        .o_hazard(w_hazRt),
        .o_fwdSel(w_fwdB)
    );

    // A taken branch squashes the ID instruction anyway, so it overrides the stall.
    assign w_stall = idValid & (w_hazRs | w_hazRt) & ~branchTaken;
    // Cycles in which nothing real enters EX.
    assign w_kill  = branchTaken | w_stall | ~idValid;

    assign w_idEntry = '{valid: 1'b1, regWrite: idRegWrite, dest: idDest, isLoad: idIsLoad};

    assign stallFetch   = w_stall;
    assign bubbleDecode = w_stall;
    assign flushIfId    = branchTaken;
    assign flushIdEx    = branchTaken;
    assign flushExMem   = branchTaken;
    assign forwardA     = r_fwdA;
    assign forwardB     = r_fwdB;
    assign stallCount   = r_stallCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sbEx     <= BUBBLE;
            r_sbMem    <= BUBBLE;
            r_sbWb     <= BUBBLE;
            r_fwdA     <= FWD_REGFILE;
            r_fwdB     <= FWD_REGFILE;
            r_stallCnt <= '0;
        end else begin
            r_sbWb  <= r_sbMem;
            r_sbMem <= branchTaken ? BUBBLE : r_sbEx;   // EX/MEM is squashed too
            r_sbEx  <= w_kill ? BUBBLE : w_idEntry;
            // Selects travel with the instruction into EX; a bubble reads nothing.
            r_fwdA  <= w_kill ? FWD_REGFILE : w_fwdA;
            r_fwdB  <= w_kill ? FWD_REGFILE : w_fwdB;
            if (w_stall && (r_stallCnt != '1))
                r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

endmodule
